clock_time_ctrl: RTL and testbench

//  Timekeeping and set-mode controller that supplies the six BCD digits to the

---
 rtl/clock_pkg.sv | 37 +++
 rtl/bcd_mod_counter.sv | 38 +++
 rtl/clock_time_ctrl.sv | 172 +++++++++++++++++
 tb/tb_clock_time_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared mode encodings, BCD digit limits and blink mask helper for the clock display controller.
package clock_pkg;

  localparam int unsigned BCD_W  = 4;
  localparam int unsigned MASK_W = 6;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'b00,
    MODE_SET_HR  = 2'b01,
    MODE_SET_MIN = 2'b10,
    MODE_BAD     = 2'b11
  } mode_e;

  localparam logic [BCD_W-1:0] UNITS_MAX         = 4'd9;
  localparam logic [BCD_W-1:0] SEC_TENS_MAX      = 4'd5;
  localparam logic [BCD_W-1:0] MIN_TENS_MAX      = 4'd5;
  localparam logic [BCD_W-1:0] HR_MAX_TENS       = 4'd2;
  localparam logic [BCD_W-1:0] HR_MAX_UNITS_AT_2 = 4'd3;

  localparam logic [MASK_W-1:0] MASK_HR  = 6'b110000;
  localparam logic [MASK_W-1:0] MASK_MIN = 6'b001100;

  // Digits to blank for the field under edit during the "off" blink phase.
  function automatic logic [MASK_W-1:0] blank_for(input mode_e m, input logic phase);
    logic [MASK_W-1:0] r;
    r = '0;
    if (phase) begin
      if (m == MODE_SET_HR) begin
        r = MASK_HR;
      end else if (m == MODE_SET_MIN) begin
        r = MASK_MIN;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Single BCD digit counting 0..MAX with synchronous clear and a combinational carry-out on wrap.
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter logic [BCD_W-1:0] MAX = UNITS_MAX
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [BCD_W-1:0] val_o,
  output logic             carry_c_o
);

  logic [BCD_W-1:0] val_q, val_d;

  // Clear has priority over increment.
  always_comb begin
    val_d = val_q;
    if (clr_i) begin
      val_d = '0;
    end else if (inc_i) begin
      val_d = (val_q == MAX) ? '0 : val_q + BCD_W'(1);
    end
  end

  assign carry_c_o = inc_i && !clr_i && (val_q == MAX);
  assign val_o     = val_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      val_q <= '0;
    end else begin
      val_q <= val_d;
    end
  end

endmodule

// File: rtl/clock_time_ctrl.sv
// HH:MM:SS BCD timekeeper with 1 Hz prescaler, RUN/SET_HR/SET_MIN mode FSM
// and blink mask for the field being set.
module clock_time_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned BLINK_DIV = 12_500_000
) (
  input  logic              in_clk,
  input  logic              in_rst_n,
  input  logic              btn_mode,
  input  logic              btn_inc,
  output logic [BCD_W-1:0]  tens_hours,
  output logic [BCD_W-1:0]  hours,
  output logic [BCD_W-1:0]  tens_minutes,
  output logic [BCD_W-1:0]  minutes,
  output logic [BCD_W-1:0]  tens_seconds,
  output logic [BCD_W-1:0]  seconds,
  output logic [MASK_W-1:0] blank_mask,
  output logic [1:0]        mode,
  output logic              tick_1hz
);

  localparam int unsigned PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_HZ - 1);
  localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_DIV - 1);

  mode_e             mode_q, mode_d;
  logic              mode_chg_c;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic              tick_q, tick_d;
  logic [BLK_W-1:0]  blk_q, blk_d;
  logic              phase_q, phase_d;
  logic [MASK_W-1:0] mask_q, mask_d;
  logic [BCD_W-1:0]  hr_t_q, hr_t_d;
  logic [BCD_W-1:0]  hr_u_q, hr_u_d;

  logic run_c, set_hr_c, set_min_c, pre_term_c;
  logic adv_c, sec_clr_c, set_inc_c, min_inc_c, hr_inc_c;
  logic s_carry_c, ts_carry_c, m_carry_c, tm_carry_c;

  // Mode FSM: btn_mode walks RUN->SET_HR->SET_MIN->RUN; the unused code falls back to RUN.
  always_comb begin
    mode_d = mode_q;
    case (mode_q)
      MODE_RUN:     if (btn_mode) mode_d = MODE_SET_HR;
      MODE_SET_HR:  if (btn_mode) mode_d = MODE_SET_MIN;
      MODE_SET_MIN: if (btn_mode) mode_d = MODE_RUN;
      default:      mode_d = MODE_RUN;
    endcase
  end

  assign mode_chg_c = (mode_d != mode_q);
  assign run_c      = (mode_q == MODE_RUN);
  assign set_hr_c   = (mode_q == MODE_SET_HR);
  assign set_min_c  = (mode_q == MODE_SET_MIN);
  assign pre_term_c = (pre_q == PRE_MAX);

  // A mode press in the same cycle swallows both the tick advance and btn_inc.
  assign adv_c     = run_c && pre_term_c && !btn_mode;
  assign sec_clr_c = run_c && btn_mode;
  assign set_inc_c = btn_inc && !btn_mode;
  assign min_inc_c = ts_carry_c || (set_min_c && set_inc_c);
  assign hr_inc_c  = (run_c && tm_carry_c) || (set_hr_c && set_inc_c);

  bcd_mod_counter #(.MAX(UNITS_MAX)) u_sec (
    .clk_i     (in_clk),
    .rst_ni    (in_rst_n),
    .inc_i     (adv_c),
    .clr_i     (sec_clr_c),
    .val_o     (seconds),
    .carry_c_o (s_carry_c)
  );

  bcd_mod_counter #(.MAX(SEC_TENS_MAX)) u_tsec (
    .clk_i     (in_clk),
    .rst_ni    (in_rst_n),
    .inc_i     (s_carry_c),
    .clr_i     (sec_clr_c),
    .val_o     (tens_seconds),
    .carry_c_o (ts_carry_c)
  );

  bcd_mod_counter #(.MAX(UNITS_MAX)) u_min (
    .clk_i     (in_clk),
    .rst_ni    (in_rst_n),
    .inc_i     (min_inc_c),
    .clr_i     (1'b0),
    .val_o     (minutes),
    .carry_c_o (m_carry_c)
  );

  // Tens-of-minutes carry only reaches hours in RUN; in SET_MIN minutes wrap alone.
  bcd_mod_counter #(.MAX(MIN_TENS_MAX)) u_tmin (
    .clk_i     (in_clk),
    .rst_ni    (in_rst_n),
    .inc_i     (m_carry_c),
    .clr_i     (1'b0),
    .val_o     (tens_minutes),
    .carry_c_o (tm_carry_c)
  );

  // Prescaler, hours, blink and registered outputs.
  always_comb begin
    tick_d  = pre_term_c;
    pre_d   = pre_term_c ? '0 : pre_q + PRE_W'(1);
    hr_t_d  = hr_t_q;
    hr_u_d  = hr_u_q;
    blk_d   = blk_q;
    phase_d = phase_q;

    if (btn_mode && (run_c || set_min_c)) begin
      pre_d = '0;
    end

    if (hr_inc_c) begin
      if (hr_t_q == HR_MAX_TENS && hr_u_q == HR_MAX_UNITS_AT_2) begin
        hr_t_d = '0;
        hr_u_d = '0;
      end else if (hr_u_q == UNITS_MAX) begin
        hr_t_d = hr_t_q + BCD_W'(1);
        hr_u_d = '0;
      end else begin
        hr_u_d = hr_u_q + BCD_W'(1);
      end
    end

    if (mode_chg_c) begin
      blk_d   = '0;
      phase_d = 1'b0;
    end else if (set_hr_c || set_min_c) begin
      if (blk_q == BLK_MAX) begin
        blk_d   = '0;
        phase_d = ~phase_q;
      end else begin
        blk_d = blk_q + BLK_W'(1);
      end
    end

    mask_d = blank_for(mode_d, phase_d);
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      mode_q  <= MODE_RUN;
      pre_q   <= '0;
      tick_q  <= 1'b0;
      blk_q   <= '0;
      phase_q <= 1'b0;
      mask_q  <= '0;
      hr_t_q  <= '0;
      hr_u_q  <= '0;
    end else begin
      mode_q  <= mode_d;
      pre_q   <= pre_d;
      tick_q  <= tick_d;
      blk_q   <= blk_d;
      phase_q <= phase_d;
      mask_q  <= mask_d;
      hr_t_q  <= hr_t_d;
      hr_u_q  <= hr_u_d;
    end
  end

  assign tens_hours = hr_t_q;
  assign hours      = hr_u_q;
  assign blank_mask = mask_q;
  assign mode       = mode_q;
  assign tick_1hz   = tick_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Self-checking bench for clock_time_ctrl: vector table, hand sequences for blink/reset,
// and random buttons against a seconds-of-day reference model.
module tb_clock_time_ctrl;

  localparam int CLK_HZ    = 4;
  localparam int BLINK_DIV = 2;

  logic       clk;
  logic       rst_n;
  logic       btn_mode;
  logic       btn_inc;
  logic [3:0] th, hu, tmn, mn, tsc, sc;
  logic [5:0] mask;
  logic [1:0] mode;
  logic       tick;

  clock_time_ctrl #(.CLK_HZ(CLK_HZ), .BLINK_DIV(BLINK_DIV)) dut (
    .in_clk       (clk),
    .in_rst_n     (rst_n),
    .btn_mode     (btn_mode),
    .btn_inc      (btn_inc),
    .tens_hours   (th),
    .hours        (hu),
    .tens_minutes (tmn),
    .minutes      (mn),
    .tens_seconds (tsc),
    .seconds      (sc),
    .blank_mask   (mask),
    .mode         (mode),
    .tick_1hz     (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: time as seconds-of-day, mode 0/1/2, counters as plain integers.
  int m_tsec, m_mode, m_pre, m_blk;
  bit m_phase, m_tick;

  function automatic void model_reset();
    m_tsec = 0; m_mode = 0; m_pre = 0; m_blk = 0; m_phase = 0; m_tick = 0;
  endfunction

  function automatic void model_step(input bit bm, input bit bi);
    bit term;
    int h, mi;
    term   = (m_pre == CLK_HZ - 1);
    m_tick = term;
    m_pre  = term ? 0 : m_pre + 1;
    h  = m_tsec / 3600;
    mi = (m_tsec / 60) % 60;
    if (bm) begin
      if (m_mode == 0) begin
        m_tsec = m_tsec - (m_tsec % 60);
        m_pre  = 0;
        m_mode = 1;
      end else if (m_mode == 1) begin
        m_mode = 2;
      end else begin
        m_pre  = 0;
        m_mode = 0;
      end
      m_blk   = 0;
      m_phase = 0;
    end else begin
      if (m_mode == 0 && term) m_tsec = (m_tsec + 1) % 86400;
      if (m_mode == 1 && bi)   m_tsec = ((h + 1) % 24) * 3600 + (m_tsec % 3600);
      if (m_mode == 2 && bi)   m_tsec = h * 3600 + ((mi + 1) % 60) * 60 + (m_tsec % 60);
      if (m_mode != 0) begin
        m_blk = m_blk + 1;
        if (m_blk == BLINK_DIV) begin
          m_blk   = 0;
          m_phase = ~m_phase;
        end
      end
    end
  endfunction

  function automatic logic [32:0] model_vec();
    int h, mi, s;
    logic [5:0] msk;
    h  = m_tsec / 3600;
    mi = (m_tsec / 60) % 60;
    s  = m_tsec % 60;
    msk = 6'b0;
    if (m_phase) msk = (m_mode == 1) ? 6'b110000 : ((m_mode == 2) ? 6'b001100 : 6'b0);
    return {4'(h / 10), 4'(h % 10), 4'(mi / 10), 4'(mi % 10), 4'(s / 10), 4'(s % 10),
            msk, 2'(m_mode), m_tick};
  endfunction

  function automatic logic [32:0] dut_vec();
    return {th, hu, tmn, mn, tsc, sc, mask, mode, tick};
  endfunction

  function automatic int dut_time();
    return int'(th) * 100000 + int'(hu) * 10000 + int'(tmn) * 1000
         + int'(mn) * 100 + int'(tsc) * 10 + int'(sc);
  endfunction

  task automatic check_eq(input string name, input logic [39:0] got, input logic [39:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One clock with the given buttons, then compare every output with the model.
  task automatic do_cycle(input bit bm, input bit bi);
    btn_mode = bm;
    btn_inc  = bi;
    @(posedge clk);
    model_step(bm, bi);
    #1;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    check_eq($sformatf("model t=%0t", $time), 40'(dut_vec()), 40'(model_vec()));
  endtask

  typedef struct {
    bit bm;
    bit bi;
    int reps;
    int idle;
    int exp_time;
    int exp_mode;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input bit bm, input bit bi, input int reps, input int idle,
                              input int t, input int m);
    vec_t v;
    v.bm = bm; v.bi = bi; v.reps = reps; v.idle = idle; v.exp_time = t; v.exp_mode = m;
    vecs.push_back(v);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Day wraps and 09/19 hour carries, reached through the set modes.
    add(1, 0, 1, 0, 0, 1);
    add(0, 1, 23, 0, 230000, 1);
    add(1, 0, 1, 0, 230000, 2);
    add(0, 1, 59, 0, 235900, 2);
    add(1, 0, 1, 0, 235900, 0);
    add(0, 0, 0, 232, 235958, 0);
    add(0, 0, 0, 4, 235959, 0);
    add(0, 0, 0, 4, 0, 0);
    add(1, 0, 1, 0, 0, 1);
    add(0, 1, 9, 0, 90000, 1);
    add(1, 0, 1, 0, 90000, 2);
    add(0, 1, 59, 0, 95900, 2);
    add(1, 0, 1, 0, 95900, 0);
    add(0, 0, 0, 236, 95959, 0);
    add(0, 0, 0, 4, 100000, 0);
    add(1, 0, 1, 0, 100000, 1);
    add(0, 1, 9, 0, 190000, 1);
    add(1, 0, 1, 0, 190000, 2);
    add(0, 1, 59, 0, 195900, 2);
    add(1, 0, 1, 0, 195900, 0);
    add(0, 0, 0, 236, 195959, 0);
    add(0, 0, 0, 4, 200000, 0);
    // Reach 12:34:56, then set hours.
    add(1, 0, 1, 0, 200000, 1);
    add(0, 1, 16, 0, 120000, 1);
    add(1, 0, 1, 0, 120000, 2);
    add(0, 1, 34, 0, 123400, 2);
    add(1, 0, 1, 0, 123400, 0);
    add(0, 0, 0, 224, 123456, 0);
    add(1, 0, 1, 0, 123400, 1);
    add(0, 1, 12, 0, 3400, 1);
    add(0, 0, 0, 12, 3400, 1);
    // Set minutes wrap without hour carry, then first increment after a full period.
    add(1, 0, 1, 0, 3400, 2);
    add(0, 1, 24, 0, 5800, 2);
    add(0, 1, 2, 0, 0, 2);
    add(1, 0, 1, 0, 0, 0);
    add(0, 0, 0, 3, 0, 0);
    add(0, 0, 0, 1, 1, 0);

    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    rst_n    = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_outputs", 40'(dut_vec()), 40'd0);
    rst_n = 1'b1;

    for (int k = 1; k <= 4; k++) begin
      do_cycle(1'b0, 1'b0);
      check_eq($sformatf("first_tick_cyc%0d", k), 40'(tick), 40'(k == 4));
    end
    check_eq("after_first_tick", 40'(dut_time()), 40'd1);

    foreach (vecs[i]) begin
      for (int r = 0; r < vecs[i].reps; r++) do_cycle(vecs[i].bm, vecs[i].bi);
      for (int r = 0; r < vecs[i].idle; r++) do_cycle(1'b0, 1'b0);
      check_eq($sformatf("vec%0d_time", i), 40'(dut_time()), 40'(vecs[i].exp_time));
      check_eq($sformatf("vec%0d_mode", i), 40'(mode), 40'(vecs[i].exp_mode));
    end

    // Blink in SET_HR: off for 2 cycles, on for 2 cycles.
    do_cycle(1'b1, 1'b0);
    check_eq("blink_enter_mask", 40'(mask), 40'd0);
    check_eq("blink_enter_mode", 40'(mode), 40'd1);
    for (int k = 1; k <= 8; k++) begin
      do_cycle(1'b0, 1'b0);
      check_eq($sformatf("blink_k%0d", k), 40'(mask),
               ((k % 4) == 2 || (k % 4) == 3) ? 40'h30 : 40'h0);
    end
    for (int k = 0; k < 3; k++) do_cycle(1'b0, 1'b1);
    do_cycle(1'b1, 1'b1);
    check_eq("collide_mode", 40'(mode), 40'd2);
    check_eq("collide_time", 40'(dut_time()), 40'd30000);
    check_eq("collide_mask", 40'(mask), 40'd0);

    // Async reset mid-SET_MIN with the prescaler at 2.
    for (int k = 0; k < 5; k++) do_cycle(1'b0, 1'b1);
    check_eq("pre_reset_time", 40'(dut_time()), 40'd30500);
    for (int k = 0; k < 8 && m_pre != 2; k++) do_cycle(1'b0, 1'b0);
    check_eq("wait_prescaler_2", 40'(m_pre), 40'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_reset_now", 40'(dut_vec()), 40'd0);
    model_reset();
    @(posedge clk);
    #1;
    check_eq("async_reset_held", 40'(dut_vec()), 40'd0);
    rst_n = 1'b1;

    for (int n = 0; n < 800; n++) begin
      do_cycle($urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
